// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM encodings (common with the
// transmitter), default sizing and the parity rule.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

  // Same convention as the transmitter: odd selects inversion of the data XOR.
  function automatic logic expected_parity(input logic odd, input logic [7:0] data);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: synchronizes rx_in, recovers 8N1/8E1/8O1 frames
// LSB first, checks parity and stop bit, and buffers good bytes in a FIFO.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          rx_in,
  input  logic                          parity_enable,
  input  logic                          parity_odd_even,
  input  logic                          rx_rd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          busy,
  output logic                          done,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          overrun,
  output logic [2:0]                    current_state
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic sync1_q, sync1_d;
  logic rx_s_q, rx_s_d;
  logic rx_p_q, rx_p_d;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;

  logic done_q, done_d;
  logic parity_error_q, parity_error_d;
  logic framing_error_q, framing_error_d;
  logic overrun_q, overrun_d;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        sample_tick;
  logic                        stop_sample;

  assign sample_tick = (cnt_q == CNT_LAST);
  assign stop_sample = (state_q == ST_STOP) && sample_tick;
  assign fifo_pop    = rx_rd && !fifo_empty;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_comb begin
    sync1_d = rx_in;
    rx_s_d  = sync1_q;
    rx_p_d  = rx_s_q;
    if (!enable) begin
      sync1_d = 1'b1;
      rx_s_d  = 1'b1;
      rx_p_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      rx_p_q  <= rx_p_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_p_q && !rx_s_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = parity_enable ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (sample_tick) begin
          cnt_d     = '0;
          par_bad_d = (rx_s_q != expected_parity(parity_odd_even, shift_q));
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      shift_d   = '0;
      par_bad_d = 1'b0;
    end
  end

  // Stop-bit verdict: framing beats parity, parity beats overrun.
  always_comb begin
    done_d          = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;
    fifo_push       = 1'b0;
    if (stop_sample) begin
      if (!rx_s_q) begin
        framing_error_d = 1'b1;
      end else if (par_bad_q) begin
        parity_error_d = 1'b1;
      end else if (fifo_full && !fifo_pop) begin
        overrun_d = 1'b1;
      end else begin
        fifo_push = 1'b1;
        done_d    = 1'b1;
      end
    end
    if (!enable) begin
      done_d          = 1'b0;
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
      overrun_d       = 1'b0;
      fifo_push       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q          <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      done_q          <= done_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (!enable),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (shift_q),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_data       = fifo_rd_data;
  assign rx_valid      = !fifo_empty;
  assign rx_count      = fifo_count;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames, checked against a queue-based model of the receive FIFO.
module tb_uart_receiver;

  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       rx_in;
  logic       parity_enable;
  logic       parity_odd_even;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       busy;
  logic       done;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  logic [2:0] current_state;

  int n_compared;
  int n_mismatched;
  int done_n, perr_n, ferr_n, ovr_n;

  logic [7:0] model_q [$];

  uart_receiver #(
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .rx_in           (rx_in),
    .parity_enable   (parity_enable),
    .parity_odd_even (parity_odd_even),
    .rx_rd           (rx_rd),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_count        (rx_count),
    .busy            (busy),
    .done            (done),
    .parity_error    (parity_error),
    .framing_error   (framing_error),
    .overrun         (overrun),
    .current_state   (current_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (done)          done_n++;
    if (parity_error)  perr_n++;
    if (framing_error) ferr_n++;
    if (overrun)       ovr_n++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] pulse_vec();
    return {8'(done_n), 8'(perr_n), 8'(ferr_n), 8'(ovr_n)};
  endfunction

  // Outcome of a frame: 0 good, 1 parity error, 2 framing error, 3 overrun.
  function automatic int frame_outcome(input logic [7:0] d, input logic pe, input logic odd,
                                       input logic pbit, input logic sbit, input int qsize);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    if (sbit == 1'b0) return 2;
    if (pe && (pbit != ((ones % 2 == 1) ? ~odd : odd))) return 1;
    if (qsize >= 16) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] outcome_vec(input int outcome);
    return 32'h0100_0000 >> (8 * outcome);
  endfunction

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (parity_enable) send_bit(pbit);
    send_bit(sbit);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                           output logic [31:0] exp_vec);
    int outcome;
    outcome = frame_outcome(d, parity_enable, parity_odd_even, pbit, sbit, model_q.size());
    send_frame(d, pbit, sbit);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    if (outcome == 0) model_q.push_back(d);
    exp_vec = outcome_vec(outcome);
  endtask

  task automatic do_read(output logic [7:0] got, output logic was_valid);
    was_valid = rx_valid;
    got       = rx_data;
    rx_rd     = 1'b1;
    @(negedge clk);
    rx_rd     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; rx_in = 1'b1; rx_rd = 1'b0;
    parity_enable = 1'b0; parity_odd_even = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if (current_state !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", current_state); end
    n_compared++;
    if ({busy, rx_valid, done, parity_error, framing_error, overrun} !== 6'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000000",
                               {busy, rx_valid, done, parity_error, framing_error, overrun});
    end
    n_compared++;
    if (rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", rx_count); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] base, exp_vec;
    logic [7:0]  got;
    logic        vld;
    parity_enable = 1'b0;
    base = pulse_vec();
    run_frame(8'hA5, 1'b0, 1'b1, exp_vec);
    n_compared++;
    if (pulse_vec() - base !== exp_vec) begin n_mismatched++; $display("[TB] FAIL basic_pulses: got %h expected %h", pulse_vec() - base, exp_vec); end
    n_compared++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin n_mismatched++; $display("[TB] FAIL basic_data: got %b/%h expected 1/a5", rx_valid, rx_data); end
    n_compared++;
    if (rx_count !== 5'd1) begin n_mismatched++; $display("[TB] FAIL basic_count: got %0d expected 1", rx_count); end
    do_read(got, vld);
    void'(model_q.pop_front());
    n_compared++;
    if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_after_read: got count %0d valid %b expected 0/0", rx_count, rx_valid); end
  endtask

  task automatic test_parity();
    logic [31:0] base, exp_vec;
    logic [7:0]  got, want;
    logic        vld;
    parity_enable = 1'b1; parity_odd_even = 1'b0;
    base = pulse_vec();
    run_frame(8'h07, 1'b1, 1'b1, exp_vec);
    n_compared++;
    if (pulse_vec() - base !== exp_vec || exp_vec !== 32'h0100_0000) begin n_mismatched++; $display("[TB] FAIL even_good_pulses: got %h expected 01000000", pulse_vec() - base); end
    want = model_q.pop_front();
    do_read(got, vld);
    n_compared++;
    if ({vld, got} !== {1'b1, want}) begin n_mismatched++; $display("[TB] FAIL even_good_data: got %b/%h expected 1/%h", vld, got, want); end
    base = pulse_vec();
    run_frame(8'h07, 1'b0, 1'b1, exp_vec);
    n_compared++;
    if (pulse_vec() - base !== 32'h0001_0000) begin n_mismatched++; $display("[TB] FAIL even_bad_pulses: got %h expected 00010000", pulse_vec() - base); end
    n_compared++;
    if (rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL even_bad_count: got %0d expected 0", rx_count); end
    parity_odd_even = 1'b1;
    base = pulse_vec();
    run_frame(8'h00, 1'b1, 1'b1, exp_vec);
    n_compared++;
    if (pulse_vec() - base !== 32'h0100_0000) begin n_mismatched++; $display("[TB] FAIL odd_good_pulses: got %h expected 01000000", pulse_vec() - base); end
    want = model_q.pop_front();
    do_read(got, vld);
    n_compared++;
    if ({vld, got} !== {1'b1, want}) begin n_mismatched++; $display("[TB] FAIL odd_good_data: got %b/%h expected 1/%h", vld, got, want); end
    parity_enable = 1'b0; parity_odd_even = 1'b0;
  endtask

  task automatic test_glitch();
    logic [31:0] base;
    base = pulse_vec();
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    n_compared++;
    if (current_state !== 3'd1) begin n_mismatched++; $display("[TB] FAIL glitch_start_state: got %0d expected 1", current_state); end
    repeat (40) @(negedge clk);
    n_compared++;
    if (current_state !== 3'd0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL glitch_idle: got state %0d busy %b expected 0/0", current_state, busy); end
    n_compared++;
    if (pulse_vec() - base !== 32'h0 || rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL glitch_quiet: got pulses %h count %0d expected 0/0", pulse_vec() - base, rx_count); end
  endtask

  task automatic test_framing_break();
    logic [31:0] base;
    logic        any_busy;
    base = pulse_vec();
    send_frame(8'h3C, 1'b0, 1'b0);
    any_busy = 1'b0;
    repeat (40 * OS) begin
      @(negedge clk);
      any_busy |= busy;
    end
    n_compared++;
    if (pulse_vec() - base !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL framing_pulses: got %h expected 00000100", pulse_vec() - base); end
    n_compared++;
    if (any_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL break_retrigger: got busy %b expected 0", any_busy); end
    n_compared++;
    if (rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL framing_count: got %0d expected 0", rx_count); end
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] base, exp_total;
    logic [7:0]  got, want;
    logic        vld;
    int          outcome;
    parity_enable = 1'b0;
    base = pulse_vec();
    exp_total = 32'h0;
    for (int i = 0; i < 17; i++) begin
      outcome = frame_outcome(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, model_q.size());
      send_frame(8'(i), 1'b0, 1'b1);
      if (outcome == 0) model_q.push_back(8'(i));
      exp_total += outcome_vec(outcome);
    end
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    n_compared++;
    if (pulse_vec() - base !== exp_total || exp_total !== 32'h1000_0001) begin n_mismatched++; $display("[TB] FAIL b2b_pulses: got %h expected 10000001", pulse_vec() - base); end
    n_compared++;
    if (rx_count !== 5'd16) begin n_mismatched++; $display("[TB] FAIL b2b_full_count: got %0d expected 16", rx_count); end
    for (int i = 0; i < 16; i++) begin
      want = model_q.pop_front();
      do_read(got, vld);
      n_compared++;
      if ({vld, got} !== {1'b1, want}) begin n_mismatched++; $display("[TB] FAIL b2b_read%0d: got %b/%h expected 1/%h", i, vld, got, want); end
    end
    n_compared++;
    if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_drained: got count %0d valid %b expected 0/0", rx_count, rx_valid); end
  endtask

  task automatic test_abort(input bit use_enable);
    logic [31:0] base, exp_vec;
    logic [7:0]  got;
    logic        vld;
    parity_enable = 1'b0;
    run_frame(8'h11, 1'b0, 1'b1, exp_vec);
    base = pulse_vec();
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    n_compared++;
    if (current_state !== 3'd2) begin n_mismatched++; $display("[TB] FAIL abort_mid_data%0d: got state %0d expected 2", use_enable, current_state); end
    rx_in = 1'b1;
    if (use_enable) enable = 1'b0; else rst = 1'b1;
    @(negedge clk);
    enable = 1'b1; rst = 1'b0;
    model_q.delete();
    n_compared++;
    if ({current_state, busy, rx_valid, rx_count} !== 10'b0) begin n_mismatched++; $display("[TB] FAIL abort_clear%0d: got state %0d busy %b valid %b count %0d expected all 0", use_enable, current_state, busy, rx_valid, rx_count); end
    repeat (8 * OS) @(negedge clk);
    n_compared++;
    if (pulse_vec() - base !== 32'h0 || rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL abort_no_push%0d: got pulses %h count %0d expected 0/0", use_enable, pulse_vec() - base, rx_count); end
    base = pulse_vec();
    run_frame(8'h55, 1'b0, 1'b1, exp_vec);
    n_compared++;
    if (pulse_vec() - base !== 32'h0100_0000 || {rx_valid, rx_data, rx_count} !== {1'b1, 8'h55, 5'd1}) begin
      n_mismatched++; $display("[TB] FAIL abort_recover%0d: got pulses %h valid %b data %h count %0d expected 01000000/1/55/1", use_enable, pulse_vec() - base, rx_valid, rx_data, rx_count);
    end
    do_read(got, vld);
    void'(model_q.pop_front());
  endtask

  task automatic test_random();
    logic [31:0] base, exp_vec;
    logic [7:0]  d, got, want;
    logic        vld, pbit, sbit, good_par;
    int          sel, nreads;
    for (int it = 0; it < 24; it++) begin
      parity_enable   = 1'($urandom_range(0, 1));
      parity_odd_even = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      sel  = $urandom_range(0, 7);
      good_par = parity_odd_even ^ (^d);
      pbit = (sel == 1) ? ~good_par : good_par;
      sbit = (sel == 0) ? 1'b0 : 1'b1;
      base = pulse_vec();
      run_frame(d, pbit, sbit, exp_vec);
      n_compared++;
      if (pulse_vec() - base !== exp_vec) begin n_mismatched++; $display("[TB] FAIL rand%0d_pulses: got %h expected %h (data %h)", it, pulse_vec() - base, exp_vec, d); end
      n_compared++;
      if (rx_count !== 5'(model_q.size())) begin n_mismatched++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, rx_count, model_q.size()); end
      nreads = (it % 6 == 5) ? 0 : $urandom_range(0, 2);
      for (int r = 0; r < nreads; r++) begin
        if (model_q.size() > 0) begin
          want = model_q.pop_front();
          do_read(got, vld);
          n_compared++;
          if ({vld, got} !== {1'b1, want}) begin n_mismatched++; $display("[TB] FAIL rand%0d_read: got %b/%h expected 1/%h", it, vld, got, want); end
        end else begin
          do_read(got, vld);
          n_compared++;
          if (vld !== 1'b0 || rx_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL rand%0d_empty_read: got valid %b count %0d expected 0/0", it, vld, rx_count); end
        end
      end
    end
    n_compared++;
    if (rx_count !== 5'(model_q.size())) begin n_mismatched++; $display("[TB] FAIL rand_final_count: got %0d expected %0d", rx_count, model_q.size()); end
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0;
    done_n = 0; perr_n = 0; ferr_n = 0; ovr_n = 0;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_framing_break();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
